// File: rtl/lsu_unit_if.sv
// Data-bus interface between the load/store unit and memory.
// The LSU drives the request side and memory returns ack/rdata.
interface lsu_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit: turns load/store control into a word-aligned bus
// transaction, stalls the core while waiting and extends load data.
module lsu_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    lsu_unit_if.master  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_n;
    logic        req, b_sz, h_sz, w_sz;
    logic        legal, aligned, accept, tmo;
    logic        fault_c;
    logic [3:0]  be_d;
    logic [31:0] wd_d;
    logic [31:0] lane, ext;

    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wd_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt;

    assign req  = mem_read | mem_write;
    assign b_sz = (funct3 == 3'b000) | (funct3 == 3'b100);
    assign h_sz = (funct3 == 3'b001) | (funct3 == 3'b101);
    assign w_sz = (funct3 == 3'b010);

    // unsigned variants only make sense for loads
    assign legal = (funct3 == 3'b000) | (funct3 == 3'b001) |
                   (funct3 == 3'b010) |
                   (~mem_write & funct3[2] & ~funct3[1]);

    assign aligned = h_sz ? ~addr[0] :
                     w_sz ? (addr[1:0] == 2'b00) : 1'b1;

    assign accept = req & legal & aligned;
    assign tmo    = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        be_d = 4'b0000;
        wd_d = wdata;
        unique case (1'b1)
            w_sz: begin
                be_d = 4'b1111;
                wd_d = wdata;
            end
            h_sz: begin
                be_d = addr[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{wdata[15:0]}};
            end
            default: begin
                be_d = 4'b0001 << addr[1:0];
                wd_d = {4{wdata[7:0]}};
            end
        endcase
    end

    assign lane = bus.bus_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = bus.bus_rdata;
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'h0, lane[7:0]};
            3'b101:  ext = {16'h0, lane[15:0]};
            default: ext = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        stall   = 1'b0;
        fault_c = 1'b0;
        unique case (state)
            IDLE: begin
                stall   = accept;
                fault_c = req & ~accept;
                if (accept) state_n = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    state_n = DONE;
                end else if (tmo) begin
                    fault_c = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign fault = fault_c & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            load_data <= '0;
            cnt       <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && accept) begin
                we_q   <= mem_write;
                addr_q <= {addr[31:2], 2'b00};
                be_q   <= be_d;
                wd_q   <= wd_d;
                f3_q   <= funct3;
                off_q  <= addr[1:0];
                cnt    <= '0;
            end
            if (state == BUSY) begin
                cnt <= cnt + 8'd1;
                if (!we_q) begin
                    if (bus.bus_ack) load_data <= ext;
                    else if (tmo)    load_data <= '0;
                end
            end
        end
    end

    assign bus.bus_req   = (state == BUSY);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wd_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: loads, stores, faults, timeout
// and reset in the middle of a transaction.
module tb_lsu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, fault;
    logic [31:0] load_data;
    int          total = 0;
    int          bad   = 0;

    lsu_unit_if bus ();

    lsu_unit #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .load_data (load_data),
        .fault     (fault),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [3:0] be, input logic [31:0] ld);
        @(negedge clk);
        mem_read = 1'b1; funct3 = f3; addr = a;
        #1;
        chk({tag, ".c0_stall"}, {31'b0, stall}, 32'd1);
        chk({tag, ".c0_req"}, {31'b0, bus.bus_req}, 32'd0);
        @(negedge clk);
        bus.bus_ack = 1'b1; bus.bus_rdata = rd;
        #1;
        chk({tag, ".c1_req"}, {31'b0, bus.bus_req}, 32'd1);
        chk({tag, ".c1_addr"}, bus.bus_addr, {a[31:2], 2'b00});
        chk({tag, ".c1_be"}, {28'b0, bus.bus_be}, {28'b0, be});
        chk({tag, ".c1_we"}, {31'b0, bus.bus_we}, 32'd0);
        chk({tag, ".c1_stall"}, {31'b0, stall}, 32'd1);
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        chk({tag, ".c2_stall"}, {31'b0, stall}, 32'd0);
        chk({tag, ".c2_req"}, {31'b0, bus.bus_req}, 32'd0);
        chk({tag, ".c2_data"}, load_data, ld);
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        chk({tag, ".after_req"}, {31'b0, bus.bus_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = '0; wdata = '0;
        bus.bus_ack = 1'b0; bus.bus_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.req", {31'b0, bus.bus_req}, 32'd0);
        chk("rst.we", {31'b0, bus.bus_we}, 32'd0);
        chk("rst.addr", bus.bus_addr, 32'd0);
        chk("rst.be", {28'b0, bus.bus_be}, 32'd0);
        chk("rst.wdata", bus.bus_wdata, 32'd0);
        chk("rst.ld", load_data, 32'd0);
        chk("rst.fault", {31'b0, fault}, 32'd0);
        chk("rst.stall", {31'b0, stall}, 32'd0);

        do_load("lw", 3'b010, 32'h1000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        do_load("lb", 3'b000, 32'h1003, 32'h80FF0000, 4'b1000, 32'hFFFFFF80);
        do_load("lbu", 3'b100, 32'h1003, 32'h80FF0000, 4'b1000, 32'h00000080);

        // SH with one wait cycle
        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'b001; addr = 32'h2002;
        wdata = 32'h1234ABCD;
        #1;
        chk("sh.c0_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("sh.req", {31'b0, bus.bus_req}, 32'd1);
        chk("sh.we", {31'b0, bus.bus_we}, 32'd1);
        chk("sh.be", {28'b0, bus.bus_be}, 32'hC);
        chk("sh.wdata", bus.bus_wdata, 32'hABCDABCD);
        chk("sh.addr", bus.bus_addr, 32'h2000);
        @(negedge clk);
        bus.bus_ack = 1'b1;
        #1;
        chk("sh.wait_stall", {31'b0, stall}, 32'd1);
        chk("sh.hold_wdata", bus.bus_wdata, 32'hABCDABCD);
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        chk("sh.done_stall", {31'b0, stall}, 32'd0);
        chk("sh.ld_kept", load_data, 32'h00000080);
        @(negedge clk);
        mem_write = 1'b0;

        // misaligned LW with a stray ack
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h1001;
        bus.bus_ack = 1'b1;
        #1;
        chk("mis.fault", {31'b0, fault}, 32'd1);
        chk("mis.stall", {31'b0, stall}, 32'd0);
        chk("mis.req", {31'b0, bus.bus_req}, 32'd0);
        @(negedge clk);
        mem_read = 1'b0; bus.bus_ack = 1'b0;
        #1;
        chk("mis.req2", {31'b0, bus.bus_req}, 32'd0);
        chk("mis.fault2", {31'b0, fault}, 32'd0);
        chk("mis.ld", load_data, 32'h00000080);

        // store with an unsigned size is illegal
        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'b100; addr = 32'h2000;
        #1;
        chk("ill.fault", {31'b0, fault}, 32'd1);
        chk("ill.stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        chk("ill.req", {31'b0, bus.bus_req}, 32'd0);

        // LH timeout after 4 BUSY cycles
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b001; addr = 32'h1002;
        #1;
        chk("to.c0_stall", {31'b0, stall}, 32'd1);
        chk("to.c0_fault", {31'b0, fault}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to.req%0d", k), {31'b0, bus.bus_req}, 32'd1);
            chk($sformatf("to.fault%0d", k), {31'b0, fault},
                (k == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #1;
        chk("to.done_req", {31'b0, bus.bus_req}, 32'd0);
        chk("to.done_fault", {31'b0, fault}, 32'd0);
        chk("to.done_stall", {31'b0, stall}, 32'd0);
        chk("to.ld", load_data, 32'd0);
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        chk("to.idle_req", {31'b0, bus.bus_req}, 32'd0);

        // LH with ack on the last allowed cycle
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b001; addr = 32'h1002;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) begin
                bus.bus_ack = 1'b1; bus.bus_rdata = 32'h80010000;
            end
            #1;
            chk($sformatf("al.fault%0d", k), {31'b0, fault}, 32'd0);
        end
        @(negedge clk);
        bus.bus_ack = 1'b0;
        #1;
        chk("al.ld", load_data, 32'hFFFF8001);
        chk("al.stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        mem_read = 1'b0;

        // reset in the 2nd BUSY cycle together with an ack
        @(negedge clk);
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h3000;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        chk("rm.busy1", {31'b0, bus.bus_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1; bus.bus_ack = 1'b1; bus.bus_rdata = 32'h12345678;
        @(negedge clk);
        rst = 1'b0; bus.bus_ack = 1'b0; mem_write = 1'b0;
        #1;
        chk("rm.req", {31'b0, bus.bus_req}, 32'd0);
        chk("rm.we", {31'b0, bus.bus_we}, 32'd0);
        chk("rm.addr", bus.bus_addr, 32'd0);
        chk("rm.be", {28'b0, bus.bus_be}, 32'd0);
        chk("rm.wdata", bus.bus_wdata, 32'd0);
        chk("rm.ld", load_data, 32'd0);
        chk("rm.fault", {31'b0, fault}, 32'd0);
        chk("rm.stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("rm.idle_req", {31'b0, bus.bus_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit for the single-cycle RISC-V core. It sits between the ALU result and the writeback result multiplexer. It turns load/store control into a handshaked, word-aligned data-bus transaction and freezes the core with `stall` while the bus responds. Loads are delivered as a sign- or zero-extended 32-bit `load_data`, which is the memory-data input of the writeback select.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles without `bus_ack` before the access is abandoned. Legal range 1–255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `mem_read` in 1: current instruction is a load.
- `mem_write` in 1: current instruction is a store. Never high together with `mem_read`.
- `funct3` in 3: access size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are legal for loads only.
- `addr` in 32: effective byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `stall` out 1: core must hold PC and instruction.
- `load_data` out 32: extended load result, registered.
- `fault` out 1: one-cycle pulse on misaligned access, illegal `funct3`, or timeout.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address; `addr` with bits [1:0] forced to 00.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: transaction complete; `bus_rdata` valid this cycle.
- `bus_rdata` in 32: read word.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - With `mem_read|mem_write`, a legal `funct3` and an aligned `addr`: latch `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`, `funct3` and `addr[1:0]`, then go to BUSY.
  - Misaligned or illegal request: no bus access, `fault`=1 this cycle, `stall`=0, `load_data` unchanged, stay in IDLE.
- **Alignment:** H/HU/SH require `addr[0]`=0. W requires `addr[1:0]`=00. B is always aligned. Illegal `funct3`: 011, 110, 111, or BU/HU with `mem_write`.
- **Byte enables:**
  - B: `bus_be` = 0001 shifted left by `addr[1:0]`.
  - H: 0011 if `addr[1]`=0, else 1100.
  - W: 1111.
  - Loads drive the same enables with `bus_we`=0.
- **Store data:** SB replicates `wdata[7:0]` into all four bytes. SH replicates `wdata[15:0]` into both halves. SW passes `wdata` through.
- **BUSY:**
  - `bus_req`=1. A wait counter increments each BUSY cycle.
  - On `bus_ack`: a load captures the extracted lane of `bus_rdata` into `load_data`. The lane is selected by the latched offset; B/H are sign-extended, BU/HU zero-extended, W passes through. Go to DONE.
  - When the counter reaches `TIMEOUT` with no ack: `fault`=1, `load_data`=0 for loads, go to DONE.
- **DONE:** `stall`=0, so the core retires the instruction this cycle. Always return to IDLE. No new access starts in DONE, even though `mem_read`/`mem_write` are still high.
- **Stall:** `stall` = (IDLE and legal aligned request) or BUSY. It is combinational from the inputs in IDLE.
- Stores never modify `load_data`.

## Timing
- **Reset values:** state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0000, `bus_wdata`=0, `load_data`=0, `fault`=0, wait counter 0.
- **Minimum access:** 3 cycles.
  - C0: IDLE, request seen, `stall`=1.
  - C1: BUSY, `bus_req`=1, `bus_ack`=1.
  - C2: DONE, `load_data` valid, `stall`=0.
- Each extra wait cycle adds one cycle.
- **Bus hold:** `bus_req` rises on the edge after C0 and falls on the edge after the ack cycle. `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` are stable while `bus_req`=1.
- **Stray ack:** `bus_ack` is ignored outside BUSY.
- **Timeout:** with `TIMEOUT`=N and no ack, BUSY lasts exactly N cycles. `fault` pulses in the last BUSY cycle, and the following cycle is DONE.
- **Ack on the last timeout cycle:** ack wins; no fault.
- **Reset mid-transaction:** `rst` high at any edge forces the reset values. An ack sampled in the same cycle as `rst` is discarded. `bus_req` is 0 in the cycle after reset.

## Test plan
- **LW:** `addr`=0x1000, ack on the first BUSY cycle, `bus_rdata`=0xDEADBEEF. Expect `bus_addr`=0x1000, `bus_be`=1111, `stall` high for 2 cycles, `load_data`=0xDEADBEEF in DONE.
- **LB / LBU:** `addr`=0x1003, `bus_rdata`=0x80FF_0000. LB gives `load_data`=0xFFFFFF80 with `bus_be`=1000; LBU gives 0x00000080.
- **SH:** `addr`=0x2002, `wdata`=0x1234ABCD. Expect `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xABCDABCD; `load_data` unchanged.
- **Misaligned LW:** `addr`=0x1001. Expect `fault` pulse, `bus_req` never asserted, `stall`=0, state stays IDLE.
- **Timeout:** `TIMEOUT`=4, no ack on LH. Expect `bus_req` high for exactly 4 cycles, `fault` in the 4th, `load_data`=0, then IDLE.
- **Reset mid-op:** `rst` during the 2nd BUSY cycle, with ack in the same cycle. Expect all outputs at reset values next cycle and `load_data`=0.
